sound_req_arbiter: RTL and testbench
====================================

Name: sound_req_arbiter

Overview:
Shares the single "play_sound" request port of the SPI play-sound device between N_REQ independent requesters (Forth core, button/event logic, etc.).
- Round-robin arbitration feeds a small synchronous FIFO.
- The FIFO head drives the device's req_sound_id/req_valid/req_ready valid-ready interface.
- Sits between the requesters and the play-sound SPI device. It queues events so the host can drain them one SPI transaction at a time.

Parameters:
N_REQ, 4, number of requesters (2..8)
DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 entries (1..4)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
in_sound_id  in  N_REQ*8  requester i sound id at bits [8*i+7:8*i]
in_valid  in  N_REQ  requester i has an event
in_ready  out  N_REQ  requester i event accepted this cycle (one-hot or zero)
out_sound_id  out  8  FIFO head, to play-sound device req_sound_id
out_valid  out  1  FIFO non-empty, to device req_valid
out_ready  in  1  from device req_ready; pop when out_valid & out_ready
fifo_level  out  DEPTH_LOG2+1  current entry count
busy  out  1  fifo_level != 0 or any in_valid

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - FIFO empty: rd/wr pointers 0, level 0, so out_valid=0 and fifo_level=0.
  - Round-robin pointer rr=0, giving requester 0 highest priority first.
  - in_ready=0 while rst is asserted.
  - Reset mid-operation discards all queued entries. Any in-flight requester handshake is not accepted.
- Arbitration (combinational):
  - can_push = (level < 2**DEPTH_LOG2).
  - Search in_valid starting at index rr, wrapping modulo N_REQ. The first set bit is winner w.
  - in_ready[w] = can_push; all other in_ready bits = 0.
  - No valid requester, or FIFO full: in_ready = 0.
- Push: on any in_ready[w] & in_valid[w], write in_sound_id[w] at wr_ptr, advance wr_ptr, and set rr = (w+1) mod N_REQ. rr is unchanged when there is no push.
- Pop: on out_valid & out_ready, advance rd_ptr.
  - out_sound_id = mem[rd_ptr]; it is a registered-storage read and is stable while out_valid=1 and no pop occurs.
  - out_sound_id is don't-care when out_valid=0.
- Pointers wrap naturally at DEPTH_LOG2 bits. Level has an extra bit to distinguish full from empty.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Full plus pop in the same cycle: no push that cycle, because can_push uses the pre-pop level. Accepting a push when full is a design error.
- Latency: event accepted at edge T is visible on out_valid/out_sound_id after edge T (1 cycle) when the FIFO was empty. There is no bypass path.
- Ordering: FIFO order equals acceptance order. At most 1 acceptance per cycle.
- Requesters must hold in_valid and in_sound_id stable until in_ready. Otherwise behaviour is unspecified but the FIFO is never corrupted.
- pw_irq of the device is driven from out_valid by the device itself. This block adds no IRQ.

Optional Feature:
Macro SOUND_ARB_DEDUP_EN.
- With the macro defined:
  - A winning request is suppressed when its id equals the id of the most recently pushed entry and that entry is still in the FIFO (level>0 and the last-pushed entry is not yet popped).
  - A suppressed request is still acknowledged (in_ready=1 when can_push), and rr advances, but nothing is written.
  - A last_id register (8 bits) and a last_valid flag track this. last_valid is cleared on reset and when the pop empties the FIFO.
- Without the macro: every accepted request is pushed, and the last_id/last_valid logic is absent.

Decomposition:
- Shared include/package sound_defs:
  - SOUND_ID_W = 8
  - CMD_PLAY_SOUND = 8'hfa
  - N_REQ default
- One sub-module: sound_fifo, a sync FIFO with params WIDTH and DEPTH_LOG2. Its ports are wdata, we, full, rdata, re, empty, level, clk, rst.
- The arbiter (round-robin search plus rr register) stays in sound_req_arbiter.

Test Plan:
- Reset then idle -> out_valid=0, fifo_level=0, in_ready=0, busy=0.
- Req1 valid id 8'h21, out_ready=0 -> in_ready=4'b0010 in that cycle; next cycle out_valid=1, out_sound_id=8'h21, fifo_level=1.
- All four requesters valid simultaneously (ids 8'h10..8'h13), out_ready=0:
  - Accept order is 0,1,2,3 over 4 cycles, then fifo_level=4 and in_ready=0.
  - Popping with out_ready=1 yields 8'h10,11,12,13.
- Full FIFO, out_ready=1 and in_valid[2]=1 in the same cycle -> no accept that cycle, level 4 then 3. The accept happens the next cycle, and level returns to 4.
- Requester 0 continuously valid, requester 3 valid -> grants alternate 0,3,0,3; no starvation.
- rst asserted with 3 entries queued -> next cycle out_valid=0 and fifo_level=0.
- With SOUND_ARB_DEDUP_EN, req0 pushes 8'h05 twice back-to-back with out_ready=0 -> both acknowledged, fifo_level=1. Without the macro -> fifo_level=2.

Source files
------------

// File: rtl/sound_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sound_defs
//  Description : Shared constants for the play-sound request path.
//  Revision    : 1.0 - initial release
// ============================================================================
package sound_defs;
    localparam int         SOUND_ID_W     = 8;
    localparam logic [7:0] CMD_PLAY_SOUND = 8'hfa;
    localparam int         N_REQ_DEFAULT  = 4;
endpackage
`default_nettype wire

// File: rtl/sound_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sound_fifo
//  Description : Synchronous FIFO, 2**DEPTH_LOG2 entries, registered storage
//                read at the head pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module sound_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  we,
    output logic                  full,
    output logic [WIDTH-1:0]      rdata,
    input  logic                  re,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_wr;
    logic                  do_rd;

    // Guard both sides so an illegal push/pop can never corrupt the pointers.
    assign do_wr = we & ~full;
    assign do_rd = re & ~empty;
    assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign rdata = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap at DEPTH_LOG2 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/sound_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sound_req_arbiter
//  Description : Round-robin arbiter sharing the play-sound request port
//                between N_REQ requesters, queued through a small FIFO.
//                Optional macro SOUND_ARB_DEDUP_EN suppresses a winning id
//                equal to the most recently pushed, still-queued entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module sound_req_arbiter
    import sound_defs::*;
#(
    parameter int N_REQ      = N_REQ_DEFAULT,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ*SOUND_ID_W-1:0] in_sound_id,
    input  logic [N_REQ-1:0]            in_valid,
    output logic [N_REQ-1:0]            in_ready,
    output logic [SOUND_ID_W-1:0]       out_sound_id,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DEPTH_LOG2:0]         fifo_level,
    output logic                        busy
);
    localparam int RR_W = $clog2(N_REQ);

    logic [RR_W-1:0]       rr;
    logic [RR_W-1:0]       winner;
    logic                  found;
    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  dup;
    logic                  push;
    logic                  pop;
    logic [SOUND_ID_W-1:0] win_id;

    // Round-robin search starting at rr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && in_valid[RR_W'(idx)]) begin
                found  = 1'b1;
                winner = RR_W'(idx);
            end
        end
    end

    // can_push is the pre-pop fullness, so a full FIFO never accepts.
    assign accept = found & ~full & ~rst;
    assign win_id = in_sound_id[winner*SOUND_ID_W +: SOUND_ID_W];
    assign push   = accept & ~dup;
    assign pop    = out_valid & out_ready;

    // One-hot grant to the winner when the FIFO has room.
    always_comb begin
        in_ready = '0;
        if (accept) in_ready[winner] = 1'b1;
    end

    // Priority moves to the requester after the one just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
        end else if (accept) begin
            rr <= (winner == RR_W'(N_REQ-1)) ? '0 : winner + 1'b1;
        end
    end

`ifdef SOUND_ARB_DEDUP_EN
    logic [SOUND_ID_W-1:0] last_id;
    logic                  last_valid;

    assign dup = last_valid && (win_id == last_id);

    // Remember the newest queued id until the FIFO drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_valid <= 1'b0;
            last_id    <= '0;
        end else if (push) begin
            last_valid <= 1'b1;
            last_id    <= win_id;
        end else if (pop && fifo_level == (DEPTH_LOG2+1)'(1)) begin
            last_valid <= 1'b0;
        end
    end
`else
    assign dup = 1'b0;
`endif

    sound_fifo #(
        .WIDTH      (SOUND_ID_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wdata (win_id),
        .we    (push),
        .full  (full),
        .rdata (out_sound_id),
        .re    (pop),
        .empty (empty),
        .level (fifo_level)
    );

    assign out_valid = ~empty;
    assign busy      = (fifo_level != '0) | (|in_valid);
endmodule
`default_nettype wire

// File: tb/tb_sound_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sound_req_arbiter
//  Description : Directed self-checking bench for sound_req_arbiter
//                (N_REQ=4, DEPTH_LOG2=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sound_req_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_sound_id;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_sound_id;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fifo_level;
    logic        busy;

    int errors = 0;
    int checks = 0;

    sound_req_arbiter #(.N_REQ(4), .DEPTH_LOG2(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_sound_id  (in_sound_id),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_sound_id (out_sound_id),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .busy         (busy)
    );

    // 10 ns clock, rising edges at 5, 15, ...
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_sound_id = '0;
        in_valid    = '0;
        out_ready   = 1'b0;
        tick();
        // A request during reset must not be granted.
        in_valid = 4'b0001;
        #1 chk("ready_in_rst", in_ready, 4'b0000);
        tick();
        rst      = 1'b0;
        in_valid = '0;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);

        // Single request from requester 1.
        in_sound_id[15:8] = 8'h21;
        in_valid = 4'b0010;
        #1 chk("req1_ready", in_ready, 4'b0010);
        chk("req1_busy", busy, 1);
        tick();
        in_valid = '0;
        #1 chk("req1_valid", out_valid, 1);
        chk("req1_id", out_sound_id, 8'h21);
        chk("req1_level", fifo_level, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("req1_drain", fifo_level, 0);

        // Reset so the round-robin pointer is back at requester 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_sound_id = 32'h13121110;
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1 chk("all_grant", in_ready, 32'(1) << i);
            tick();
            in_valid[i] = 1'b0;
        end
        chk("all_level_full", fifo_level, 4);
        in_valid = 4'b1111;
        #1 chk("full_no_ready", in_ready, 0);

        // Full plus pop: no accept this cycle, accept on the next.
        in_valid = 4'b0100;
        in_sound_id[23:16] = 8'h42;
        out_ready = 1'b1;
        #1 chk("fullpop_ready", in_ready, 0);
        chk("fullpop_head", out_sound_id, 8'h10);
        tick();
        out_ready = 1'b0;
        chk("fullpop_level3", fifo_level, 3);
        #1 chk("fullpop_ready2", in_ready, 4'b0100);
        tick();
        in_valid = '0;
        chk("fullpop_level4", fifo_level, 4);
        out_ready = 1'b1;
        chk("pop_id0", out_sound_id, 8'h11);
        tick();
        chk("pop_id1", out_sound_id, 8'h12);
        tick();
        chk("pop_id2", out_sound_id, 8'h13);
        tick();
        chk("pop_id3", out_sound_id, 8'h42);
        tick();
        chk("pop_empty", out_valid, 0);

        // Requesters 0 and 3 contend; rr is at 3 after serving requester 2.
        in_sound_id = 32'hA30000A0;
        in_valid = 4'b1001;
        #1 chk("alt_g0", in_ready, 4'b1000);
        tick();
        chk("alt_g1", in_ready, 4'b0001);
        tick();
        chk("alt_g2", in_ready, 4'b1000);
        tick();
        chk("alt_g3", in_ready, 4'b0001);
        tick();
        in_valid = '0;
        tick();
        chk("alt_drain", fifo_level, 0);

        // Reset discards three queued entries.
        out_ready = 1'b0;
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            in_sound_id[15:8] = 8'h31 + 8'(i);
            tick();
        end
        in_valid = '0;
        chk("q3_level", fifo_level, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("q3_rst_valid", out_valid, 0);
        chk("q3_rst_level", fifo_level, 0);

        // Same id pushed twice back-to-back by requester 0.
        in_sound_id = 32'h00000005;
        in_valid = 4'b0001;
        #1 chk("dup_ready0", in_ready, 4'b0001);
        tick();
        chk("dup_ready1", in_ready, 4'b0001);
        tick();
        in_valid = '0;
`ifdef SOUND_ARB_DEDUP_EN
        chk("dup_level", fifo_level, 1);
`else
        chk("dup_level", fifo_level, 2);
`endif
        chk("dup_head", out_sound_id, 8'h05);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
